// File: rtl/cpu_mem_responder.sv
// Processor-side word memory with a program loader that streams an image
// to the reset PC while holding the core in reset.
module cpu_mem_responder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 14'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_inaddr,
  input  logic [DATA_W-1:0] m_indata,
  input  logic              m_read1,
  input  logic              m_read2,
  input  logic              m_read3,
  input  logic              m_read4,
  input  logic [ADDR_W-1:0] m_outaddr1,
  input  logic [ADDR_W-1:0] m_outaddr2,
  input  logic [ADDR_W-1:0] m_outaddr3,
  input  logic [ADDR_W-1:0] m_outaddr4,
  output logic [DATA_W-1:0] m_outdata1,
  output logic [DATA_W-1:0] m_outdata2,
  output logic [DATA_W-1:0] m_outdata3,
  output logic [DATA_W-1:0] m_outdata4,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ld_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign cnt_nxt = ld_count + 1'b1;

  // Processor and loader never share a cycle: the core is held while loading.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = m_inaddr;
    mem_wdata = m_indata;
    unique case (1'b1)
      state == ST_IDLE: mem_we = m_write;
      state == ST_LOAD: begin
        mem_we    = ld_valid;
        mem_waddr = LOAD_BASE + ld_count;
        mem_wdata = ld_data;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign m_outdata1 = m_read1 ? mem[m_outaddr1] : '0;
  assign m_outdata2 = m_read2 ? mem[m_outaddr2] : '0;
  assign m_outdata3 = m_read3 ? mem[m_outaddr3] : '0;
  assign m_outdata4 = m_read4 ? mem[m_outaddr4] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      ld_count <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ld_start && (ld_len != '0)) begin
            state    <= ST_LOAD;
            len_q    <= ld_len;
            ld_count <= '0;
            ld_ready <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ld_count <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state    <= ST_DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (normal and wrapping load base)
// driven in lockstep and compared against a transaction-level model.
module tb_cpu_mem_responder;

  localparam int AW = 14;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_inaddr = '0;
  logic [DW-1:0] m_indata = '0;
  logic          m_read [1:4];
  logic [AW-1:0] m_outaddr [1:4];
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;

  logic [DW-1:0] rd [2][1:4];
  logic          rdy [2];
  logic          dn [2];
  logic          hold [2];
  logic [AW-1:0] cnt [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.LOAD_BASE(14'h2000)) u_dut0 (
    .clk(clk), .rst(rst),
    .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
    .m_read1(m_read[1]), .m_read2(m_read[2]),
    .m_read3(m_read[3]), .m_read4(m_read[4]),
    .m_outaddr1(m_outaddr[1]), .m_outaddr2(m_outaddr[2]),
    .m_outaddr3(m_outaddr[3]), .m_outaddr4(m_outaddr[4]),
    .m_outdata1(rd[0][1]), .m_outdata2(rd[0][2]),
    .m_outdata3(rd[0][3]), .m_outdata4(rd[0][4]),
    .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(rdy[0]), .ld_done(dn[0]),
    .cpu_hold(hold[0]), .ld_count(cnt[0])
  );

  cpu_mem_responder #(.LOAD_BASE(14'h3FFF)) u_dut1 (
    .clk(clk), .rst(rst),
    .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
    .m_read1(m_read[1]), .m_read2(m_read[2]),
    .m_read3(m_read[3]), .m_read4(m_read[4]),
    .m_outaddr1(m_outaddr[1]), .m_outaddr2(m_outaddr[2]),
    .m_outaddr3(m_outaddr[3]), .m_outaddr4(m_outaddr[4]),
    .m_outdata1(rd[1][1]), .m_outdata2(rd[1][2]),
    .m_outdata3(rd[1][3]), .m_outdata4(rd[1][4]),
    .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(rdy[1]), .ld_done(dn[1]),
    .cpu_hold(hold[1]), .ld_count(cnt[1])
  );

  // Reference model: load session flags plus a sparse memory per instance.
  bit            loading = 1'b0;
  bit            finishing = 1'b0;
  logic          m_rdy = 1'b0;
  logic          m_dn = 1'b0;
  logic          m_hold = 1'b0;
  logic [AW-1:0] m_cnt = '0;
  logic [AW-1:0] m_len = '0;
  logic [DW-1:0] mem0 [int];
  logic [DW-1:0] mem1 [int];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    if (!rst) begin
      loading   = 1'b0;
      finishing = 1'b0;
      m_rdy     = 1'b0;
      m_dn      = 1'b0;
      m_hold    = 1'b0;
      m_cnt     = '0;
      m_len     = '0;
      return;
    end
    m_dn = 1'b0;
    if (finishing) begin
      finishing = 1'b0;
      m_hold    = 1'b0;
    end else if (loading) begin
      if (ld_valid) begin
        a0 = 14'h2000 + m_cnt;
        a1 = 14'h3FFF + m_cnt;
        mem0[int'(a0)] = ld_data;
        mem1[int'(a1)] = ld_data;
        m_cnt++;
        if (m_cnt == m_len) begin
          loading   = 1'b0;
          finishing = 1'b1;
          m_dn      = 1'b1;
          m_rdy     = 1'b0;
        end
      end
    end else begin
      if (m_write) begin
        mem0[int'(m_inaddr)] = m_indata;
        mem1[int'(m_inaddr)] = m_indata;
      end
      if (ld_start && ld_len != '0) begin
        loading = 1'b1;
        m_len   = ld_len;
        m_cnt   = '0;
        m_rdy   = 1'b1;
        m_hold  = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int a;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(m_rdy));
      check($sformatf("d%0d_done", d), 32'(dn[d]), 32'(m_dn));
      check($sformatf("d%0d_hold", d), 32'(hold[d]), 32'(m_hold));
      check($sformatf("d%0d_count", d), 32'(cnt[d]), 32'(m_cnt));
      for (int p = 1; p <= 4; p++) begin
        a = int'(m_outaddr[p]);
        if (!m_read[p]) begin
          check($sformatf("d%0d_rd%0d_off", d, p), 32'(rd[d][p]), 32'h0);
        end else if (d == 0 && mem0.exists(a)) begin
          check($sformatf("d0_rd%0d_%h", p, a), 32'(rd[d][p]), 32'(mem0[a]));
        end else if (d == 1 && mem1.exists(a)) begin
          check($sformatf("d1_rd%0d_%h", p, a), 32'(rd[d][p]), 32'(mem1[a]));
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    m_write  = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    for (int p = 1; p <= 4; p++) m_read[p] = 1'b0;
  endtask

  task automatic rd_at(input int p, input logic [AW-1:0] a);
    m_read[p]    = 1'b1;
    m_outaddr[p] = a;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    unique case ($urandom_range(0, 4))
      0: return 14'h2000 + 14'($urandom_range(0, 7));
      1: return 14'($urandom_range(0, 7));
      2: return 14'h3FFF;
      3: return 14'h0010;
      default: return 14'h0020;
    endcase
  endfunction

  initial begin
    for (int p = 1; p <= 4; p++) begin
      m_read[p]    = 1'b0;
      m_outaddr[p] = '0;
    end
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b1;
    cycle();

    m_write = 1'b1; m_inaddr = 14'h0010; m_indata = 10'h2AB;
    cycle();
    quiet(); rd_at(4, 14'h0010);
    cycle();
    m_read[4] = 1'b0;
    cycle();

    m_write = 1'b1; m_inaddr = 14'h0020; m_indata = 10'h0AA;
    cycle();
    m_indata = 10'h155; rd_at(1, 14'h0020);
    cycle();
    m_write = 1'b0;
    cycle();
    quiet();

    ld_start = 1'b1; ld_len = 14'd3;
    cycle();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 10'h001;
    cycle();
    ld_valid = 1'b0;
    cycle();
    ld_valid = 1'b1; ld_data = 10'h002;
    m_write = 1'b1; m_inaddr = 14'h2000; m_indata = 10'h3FF;
    cycle();
    ld_data = 10'h003;
    cycle();
    quiet();
    cycle();
    cycle();
    rd_at(1, 14'h2000); rd_at(2, 14'h2001); rd_at(3, 14'h2002);
    cycle();
    quiet();

    ld_start = 1'b1; ld_len = 14'd0;
    cycle();
    ld_start = 1'b0;
    cycle();

    ld_start = 1'b1; ld_len = 14'd5;
    cycle();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 10'h0F0;
    cycle();
    ld_data = 10'h0F1;
    cycle();
    ld_valid = 1'b0; rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rd_at(1, 14'h2000); rd_at(2, 14'h2001);
    rd_at(3, 14'h3FFF); rd_at(4, 14'h0000);
    cycle();
    quiet();

    ld_start = 1'b1; ld_len = 14'd2;
    cycle();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 10'h111;
    cycle();
    ld_data = 10'h222;
    cycle();
    quiet();
    cycle();
    rd_at(1, 14'h3FFF); rd_at(2, 14'h0000);
    cycle();
    quiet();

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) != 0);
      m_write  = ($urandom_range(0, 2) == 0);
      m_inaddr = pick_addr();
      m_indata = 10'($urandom);
      for (int p = 1; p <= 4; p++) begin
        m_read[p]    = ($urandom_range(0, 1) == 1);
        m_outaddr[p] = pick_addr();
      end
      ld_start = ($urandom_range(0, 14) == 0);
      ld_len   = 14'($urandom_range(0, 6));
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_data  = 10'($urandom);
      cycle();
    end
    rst = 1'b1;
    quiet();
    for (int i = 0; i < 10; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
